seq_stim_tx: RTL and testbench

- Serial stimulus transmitter: emits a programmed bit pattern, MSB first, one bit per enabled cycle, on a single-bit stream.
- Drives the serial data input of the team's sequence-detector FSMs, so it is the sending end of that bit-stream interface.
- Used in benches and on-chip self-test to replay known sequences, including repeated back-to-back patterns.

---
 rtl/seq_stim_tx_if.sv | 40 ++++
 rtl/seq_stim_tx.sv | 182 ++++++++++++++++++
 tb/tb_seq_stim_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_stim_tx_if.sv
// Bit-stream stimulus interface between a serial transmitter and its controller/consumer.
//   master : the transmitter (seq_stim_tx); drives dout, dout_vld, busy, done and
//            receives start, abort, en, pat, pat_len, rep.
//   slave  : the controlling/consuming side; drives the requests, observes the stream.
// Optional macro SEQ_STIM_TX_PRBS_EN adds the prbs_mode request signal.
interface seq_stim_tx_if #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned REP_W = 4
);
   logic             start;
   logic             abort;
   logic             en;
   logic [PAT_W-1:0] pat;
   logic [LEN_W-1:0] pat_len;
   logic [REP_W-1:0] rep;
`ifdef SEQ_STIM_TX_PRBS_EN
   logic             prbs_mode;
`endif
   logic             dout;
   logic             dout_vld;
   logic             busy;
   logic             done;

   modport master (
      input  start, abort, en, pat, pat_len, rep,
`ifdef SEQ_STIM_TX_PRBS_EN
      input  prbs_mode,
`endif
      output dout, dout_vld, busy, done
   );

   modport slave (
      output start, abort, en, pat, pat_len, rep,
`ifdef SEQ_STIM_TX_PRBS_EN
      output prbs_mode,
`endif
      input  dout, dout_vld, busy, done
   );
endinterface

// File: rtl/seq_stim_tx.sv
// Serial stimulus transmitter: replays a latched bit pattern MSB first, one bit per enabled
// cycle, rep+1 times back to back, then pulses done.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_stim_tx_if master modport
//            in : start, abort, en, pat, pat_len, rep (prbs_mode with the macro)
//            out: dout, dout_vld, busy, done (all registered)
// Optional macro SEQ_STIM_TX_PRBS_EN: adds prbs_mode; when set at start, bits come from a
// PRBS7 LFSR (x^7+x^6+1) seeded 7'h7F instead of the pattern.
module seq_stim_tx #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned REP_W = 4
) (
   input logic           clk,
   input logic           rst_n,
   seq_stim_tx_if.master bus
);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             fin_q, fin_d;   // every bit of every repetition has been presented
   logic             dout_q, dout_d;
   logic             vld_q, vld_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [LEN_W-1:0] len_eff;
   logic             accept;
   logic             advance;
   logic             pat_bit;
   logic             tx_bit;

`ifdef SEQ_STIM_TX_PRBS_EN
   logic       prbs_q, prbs_d;
   logic [6:0] lfsr_q, lfsr_d;
`endif

   // Out-of-range lengths fall back to the full pattern width.
   always_comb begin
      if (bus.pat_len == '0 || 32'(bus.pat_len) > PAT_W) begin
         len_eff = LEN_W'(PAT_W);
      end else begin
         len_eff = bus.pat_len;
      end
   end

   assign accept  = (state_q == StIdle) && bus.start && !bus.abort;
   assign advance = (state_q == StSend) && bus.en && !bus.abort && !fin_q;
   assign pat_bit = |(pat_q & (PAT_W'(1) << idx_q));

`ifdef SEQ_STIM_TX_PRBS_EN
   assign tx_bit = prbs_q ? lfsr_q[6] : pat_bit;
`else
   assign tx_bit = pat_bit;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pat_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         fin_q   <= 1'b0;
         dout_q  <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_STIM_TX_PRBS_EN
         prbs_q  <= 1'b0;
         lfsr_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         fin_q   <= fin_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SEQ_STIM_TX_PRBS_EN
         prbs_q  <= prbs_d;
         lfsr_q  <= lfsr_d;
`endif
      end
   end

   // Next state and bit/repeat bookkeeping
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      fin_d   = fin_q;
`ifdef SEQ_STIM_TX_PRBS_EN
      prbs_d  = prbs_q;
      lfsr_d  = lfsr_q;
`endif

      unique case (state_q)
         StIdle: if (accept) state_d = StSend;
         StSend: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (bus.en && fin_q) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (accept) begin
         pat_d  = bus.pat;
         len_d  = len_eff;
         idx_d  = len_eff - LEN_W'(1);
         rep_d  = bus.rep;
         fin_d  = 1'b0;
`ifdef SEQ_STIM_TX_PRBS_EN
         prbs_d = bus.prbs_mode;
         lfsr_d = 7'h7F;
`endif
      end else if (advance) begin
         // Bit 0 just went out: wrap for another repetition or mark the transfer finished.
         if (idx_q == '0) begin
            if (rep_q == '0) begin
               fin_d = 1'b1;
            end else begin
               rep_d = rep_q - REP_W'(1);
               idx_d = len_q - LEN_W'(1);
            end
         end else begin
            idx_d = idx_q - LEN_W'(1);
         end
`ifdef SEQ_STIM_TX_PRBS_EN
         lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
`endif
      end
   end

   // Registered outputs, decoded from the upcoming state
   always_comb begin
      dout_d = dout_q;
      vld_d  = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      unique case (state_d)
         StIdle: dout_d = 1'b0;
         StSend: begin
            busy_d = 1'b1;
            if (advance) begin
               dout_d = tx_bit;
               vld_d  = 1'b1;
            end
         end
         StDone: begin
            busy_d = 1'b1;
            done_d = 1'b1;
            dout_d = 1'b0;
         end
         default: dout_d = 1'b0;
      endcase
   end

   assign bus.dout     = dout_q;
   assign bus.dout_vld = vld_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_stim_tx.sv
// Directed self-checking bench for seq_stim_tx.
module tb_seq_stim_tx;
   localparam int unsigned PAT_W = 8;
   localparam int unsigned LEN_W = 4;
   localparam int unsigned REP_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   seq_stim_tx_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

   seq_stim_tx #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.en      = 1'b1;
      bus.pat     = '0;
      bus.pat_len = '0;
      bus.rep     = '0;
`ifdef SEQ_STIM_TX_PRBS_EN
      bus.prbs_mode = 1'b0;
`endif
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({bus.dout, bus.dout_vld, bus.busy, bus.done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=0000",
                  {bus.dout, bus.dout_vld, bus.busy, bus.done});
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({bus.dout, bus.dout_vld, bus.busy, bus.done} !== 4'b0000) begin
         failures++;
         $display("FAIL post_reset_idle got=%b want=0000",
                  {bus.dout, bus.dout_vld, bus.busy, bus.done});
      end
   endtask

   task automatic test_single();
      logic [3:0] exp;
      exp = 4'b1101;
      bus.pat = 8'hFD; bus.pat_len = 4'd4; bus.rep = '0; bus.en = 1'b1; bus.start = 1'b1;
      step();  // edge 0
      bus.start = 1'b0;
      checks++;
      if ({bus.busy, bus.dout_vld} !== 2'b10) begin
         failures++;
         $display("FAIL single_latency busy,vld got=%b want=10", {bus.busy, bus.dout_vld});
      end
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if ({bus.dout_vld, bus.dout, bus.done} !== {1'b1, exp[4-i], 1'b0}) begin
            failures++;
            $display("FAIL single_bit%0d vld,dout,done got=%b want=%b", i,
                     {bus.dout_vld, bus.dout, bus.done}, {1'b1, exp[4-i], 1'b0});
         end
      end
      step();  // edge 5
      checks++;
      if ({bus.done, bus.busy, bus.dout_vld, bus.dout} !== 4'b1100) begin
         failures++;
         $display("FAIL single_done done,busy,vld,dout got=%b want=1100",
                  {bus.done, bus.busy, bus.dout_vld, bus.dout});
      end
      step();  // edge 6
      checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         failures++;
         $display("FAIL single_idle done,busy got=%b want=00", {bus.done, bus.busy});
      end
   endtask

   task automatic test_repeat();
      logic [15:0] bits;
      int nbits, ndone, first, last, done_cyc;
      bits = '0; nbits = 0; ndone = 0; first = -1; last = -1; done_cyc = -1;
      bus.pat = 8'b0000_0110; bus.pat_len = 4'd3; bus.rep = 4'd2; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (bus.dout_vld) begin
            bits = {bits[14:0], bus.dout};
            nbits++;
            if (first < 0) first = c;
            last = c;
         end
         if (bus.done) begin
            ndone++;
            done_cyc = c;
         end
      end
      checks++;
      if (nbits != 9) begin
         failures++;
         $display("FAIL repeat_count got=%0d want=9", nbits);
      end
      checks++;
      if (bits !== 16'h01B6) begin
         failures++;
         $display("FAIL repeat_bits got=%b want=%b", bits, 16'h01B6);
      end
      checks++;
      if (first != 1 || last != 9) begin
         failures++;
         $display("FAIL repeat_no_gap first=%0d last=%0d want 1 and 9", first, last);
      end
      checks++;
      if (ndone != 1 || done_cyc != 10) begin
         failures++;
         $display("FAIL repeat_done count=%0d cycle=%0d want 1 at 10", ndone, done_cyc);
      end
   endtask

   task automatic test_stall();
      logic [1:7] en_v, vld_v, dout_v, done_v;
      en_v   = 7'b1001111;
      vld_v  = 7'b1001110;
      dout_v = 7'b1111010;
      done_v = 7'b0000001;
      bus.pat = 8'hFD; bus.pat_len = 4'd4; bus.rep = '0; bus.en = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         bus.en = en_v[i];
         step();
         checks++;
         if ({bus.dout_vld, bus.dout, bus.done} !== {vld_v[i], dout_v[i], done_v[i]}) begin
            failures++;
            $display("FAIL stall_edge%0d vld,dout,done got=%b want=%b", i,
                     {bus.dout_vld, bus.dout, bus.done}, {vld_v[i], dout_v[i], done_v[i]});
         end
      end
      bus.en = 1'b1;
      step();
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL stall_idle busy got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_len_busy();
      logic [15:0] bits;
      int nbits, ndone, done_cyc;
      // Length 0 means full width; a start mid-transfer must be ignored.
      bits = '0; nbits = 0; ndone = 0; done_cyc = -1;
      bus.pat = 8'hA5; bus.pat_len = 4'd0; bus.rep = '0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 3) begin
            bus.start = 1'b1; bus.pat = 8'hFF; bus.pat_len = 4'd2; bus.rep = 4'd3;
         end
         if (c == 4) bus.start = 1'b0;
         step();
         if (bus.dout_vld) begin
            bits = {bits[14:0], bus.dout};
            nbits++;
         end
         if (bus.done) begin
            ndone++;
            done_cyc = c;
         end
      end
      checks++;
      if (nbits != 8 || bits !== 16'h00A5) begin
         failures++;
         $display("FAIL len0_bits n=%0d got=%h want 8 bits a5", nbits, bits);
      end
      checks++;
      if (ndone != 1 || done_cyc != 9) begin
         failures++;
         $display("FAIL len0_done count=%0d cycle=%0d want 1 at 9", ndone, done_cyc);
      end
      // Length above PAT_W also means full width.
      bits = '0; nbits = 0;
      bus.pat = 8'h3C; bus.pat_len = 4'd12; bus.rep = '0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (bus.dout_vld) begin
            bits = {bits[14:0], bus.dout};
            nbits++;
         end
      end
      checks++;
      if (nbits != 8 || bits !== 16'h003C) begin
         failures++;
         $display("FAIL len12_bits n=%0d got=%h want 8 bits 3c", nbits, bits);
      end
   endtask

   task automatic test_abort();
      int nact;
      // Abort while the 3rd bit is on the line.
      bus.pat = 8'b1011_0011; bus.pat_len = 4'd8; bus.rep = 4'd1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step(); step(); step();
      checks++;
      if ({bus.dout_vld, bus.dout} !== 2'b11) begin
         failures++;
         $display("FAIL abort_third_bit vld,dout got=%b want=11", {bus.dout_vld, bus.dout});
      end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      checks++;
      if ({bus.busy, bus.dout_vld, bus.dout, bus.done} !== 4'b0000) begin
         failures++;
         $display("FAIL abort_idle got=%b want=0000",
                  {bus.busy, bus.dout_vld, bus.dout, bus.done});
      end
      nact = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (bus.busy || bus.dout_vld || bus.done) nact++;
      end
      checks++;
      if (nact != 0) begin
         failures++;
         $display("FAIL abort_quiet active_cycles got=%0d want=0", nact);
      end
      // Asynchronous reset mid-transfer.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step(); step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.dout_vld, bus.dout, bus.done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_mid got=%b want=0000",
                  {bus.busy, bus.dout_vld, bus.dout, bus.done});
      end
      step();
      rst_n = 1'b1;
      nact = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (bus.busy || bus.dout_vld || bus.done) nact++;
      end
      checks++;
      if (nact != 0) begin
         failures++;
         $display("FAIL reset_quiet active_cycles got=%0d want=0", nact);
      end
      // start together with abort in IDLE.
      bus.start = 1'b1; bus.abort = 1'b1;
      step();
      bus.start = 1'b0; bus.abort = 1'b0;
      nact = (bus.busy || bus.dout_vld || bus.done) ? 1 : 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (bus.busy || bus.dout_vld || bus.done) nact++;
      end
      checks++;
      if (nact != 0) begin
         failures++;
         $display("FAIL start_abort_idle active_cycles got=%0d want=0", nact);
      end
   endtask

`ifdef SEQ_STIM_TX_PRBS_EN
   task automatic test_prbs();
      logic [15:0] bits;
      int nbits, done_cyc;
      bits = '0; nbits = 0; done_cyc = -1;
      bus.prbs_mode = 1'b1; bus.pat = 8'h00; bus.pat_len = 4'd7; bus.rep = '0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.prbs_mode = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (bus.dout_vld) begin
            bits = {bits[14:0], bus.dout};
            nbits++;
         end
         if (bus.done) done_cyc = c;
      end
      checks++;
      if (nbits != 7 || bits !== 16'h007F) begin
         failures++;
         $display("FAIL prbs_bits n=%0d got=%h want 7 bits 7f", nbits, bits);
      end
      checks++;
      if (done_cyc != 8) begin
         failures++;
         $display("FAIL prbs_done cycle got=%0d want=8", done_cyc);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_repeat();
      test_stall();
      test_len_busy();
      test_abort();
`ifdef SEQ_STIM_TX_PRBS_EN
      test_prbs();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
